// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the hh:mm:ss clock: one-second tick prescaler plus the
// button-driven time-set FSM that freezes the clock, edits a field and loads it back.
module clock_set_ctrl #(
   parameter int         CLK_DIV = 50_000_000,
   parameter logic [5:0] SEC_MAX = 6'd59,
   parameter logic [5:0] MIN_MAX = 6'd59,
   parameter logic [5:0] HRS_MAX = 6'd23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic       dec_btn,
   input  logic [5:0] cur_sec,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_hrs,
   output logic       tick_en,
   output logic       load,
   output logic [5:0] set_sec,
   output logic [5:0] set_min,
   output logic [5:0] set_hrs,
   output logic [1:0] edit_field,
   output logic       blink
);

   localparam int            PW         = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_DIV / 2);

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_SET_HRS = 3'd1,
      ST_SET_MIN = 3'd2,
      ST_SET_SEC = 3'd3,
      ST_COMMIT  = 3'd4
   } state_t;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
      if (v >= max) return 6'd0;
      else          return v + 6'd1;
   endfunction

   function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
      if (v == 6'd0) return max;
      else           return v - 6'd1;
   endfunction

   state_t        state_r, state_next_s;
   logic [PW-1:0] presc_r, presc_next_s;
   logic          tick_en_r, tick_next_s;
   logic          load_r, load_next_s;
   logic          blink_r, blink_next_s;
   logic [1:0]    edit_field_r, edit_field_next_s;
   logic [5:0]    set_sec_r, set_min_r, set_hrs_r;
   logic [5:0]    set_sec_next_s, set_min_next_s, set_hrs_next_s;
   logic          edit_s, in_set_next_s;

   // Mode wins over edits, and inc together with dec cancels out.
   assign edit_s = !mode_btn && (inc_btn ^ dec_btn);

   // Next-state logic: mode_btn walks the edit states; COMMIT always falls back to RUN.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_RUN:     if (mode_btn) state_next_s = ST_SET_HRS; else state_next_s = ST_RUN;
         ST_SET_HRS: if (mode_btn) state_next_s = ST_SET_MIN; else state_next_s = ST_SET_HRS;
         ST_SET_MIN: if (mode_btn) state_next_s = ST_SET_SEC; else state_next_s = ST_SET_MIN;
         ST_SET_SEC: if (mode_btn) state_next_s = ST_COMMIT;  else state_next_s = ST_SET_SEC;
         ST_COMMIT:  state_next_s = ST_RUN;
         default:    state_next_s = ST_RUN;
      endcase
   end

   // Output and datapath next values; every output is registered from these.
   always_comb begin
      if (state_next_s == ST_COMMIT)  presc_next_s = '0;
      else if (presc_r == PRESC_LAST) presc_next_s = '0;
      else                            presc_next_s = presc_r + PW'(1'b1);

      tick_next_s   = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
      load_next_s   = (state_next_s == ST_COMMIT);
      in_set_next_s = (state_next_s == ST_SET_HRS) || (state_next_s == ST_SET_MIN) ||
                      (state_next_s == ST_SET_SEC);
      blink_next_s  = in_set_next_s && (presc_next_s >= PRESC_HALF);

      case (state_next_s)
         ST_SET_HRS: edit_field_next_s = 2'd1;
         ST_SET_MIN: edit_field_next_s = 2'd2;
         ST_SET_SEC: edit_field_next_s = 2'd3;
         default:    edit_field_next_s = 2'd0;
      endcase

      set_hrs_next_s = set_hrs_r;
      set_min_next_s = set_min_r;
      set_sec_next_s = set_sec_r;
      case (state_r)
         ST_RUN: begin
            if (mode_btn) begin
               set_hrs_next_s = cur_hrs;
               set_min_next_s = cur_min;
               set_sec_next_s = cur_sec;
            end else begin
               set_hrs_next_s = set_hrs_r;
            end
         end
         ST_SET_HRS: begin
            if (edit_s) set_hrs_next_s = inc_btn ? wrap_inc(set_hrs_r, HRS_MAX) : wrap_dec(set_hrs_r, HRS_MAX);
            else        set_hrs_next_s = set_hrs_r;
         end
         ST_SET_MIN: begin
            if (edit_s) set_min_next_s = inc_btn ? wrap_inc(set_min_r, MIN_MAX) : wrap_dec(set_min_r, MIN_MAX);
            else        set_min_next_s = set_min_r;
         end
         ST_SET_SEC: begin
            if (edit_s) set_sec_next_s = inc_btn ? wrap_inc(set_sec_r, SEC_MAX) : wrap_dec(set_sec_r, SEC_MAX);
            else        set_sec_next_s = set_sec_r;
         end
         default: set_hrs_next_s = set_hrs_r;
      endcase
   end

   // State, prescaler and output registers; reset drops any edit in progress without a load.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_RUN;
         presc_r      <= '0;
         tick_en_r    <= 1'b0;
         load_r       <= 1'b0;
         blink_r      <= 1'b0;
         edit_field_r <= 2'd0;
         set_hrs_r    <= 6'd0;
         set_min_r    <= 6'd0;
         set_sec_r    <= 6'd0;
      end else begin
         state_r      <= state_next_s;
         presc_r      <= presc_next_s;
         tick_en_r    <= tick_next_s;
         load_r       <= load_next_s;
         blink_r      <= blink_next_s;
         edit_field_r <= edit_field_next_s;
         set_hrs_r    <= set_hrs_next_s;
         set_min_r    <= set_min_next_s;
         set_sec_r    <= set_sec_next_s;
      end
   end

   assign tick_en    = tick_en_r;
   assign load       = load_r;
   assign blink      = blink_r;
   assign edit_field = edit_field_r;
   assign set_hrs    = set_hrs_r;
   assign set_min    = set_min_r;
   assign set_sec    = set_sec_r;

endmodule
